// File: rtl/dc_offset_remover.sv
// Removes a constant DC offset from a sample stream. The offset starts at a nominal value and is
// then re-estimated as the average of each window of 2^avg_log2 accepted samples.
//
// state  | meaning
// WARMUP | no window finished yet; nominal init_offset is applied
// TRACK  | offset_o holds the average of the most recent finished window
module dc_offset_remover #(
  parameter int width_H     = 5,
  parameter int width_W     = 20,
  parameter int init_offset = 65536,
  parameter int avg_log2    = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              data_i_en,
  input  logic signed [width_H+width_W-1:0] data_i,
  input  logic                              freeze,
  output logic                              data_o_en,
  output logic signed [width_H+width_W-1:0] data_o,
  output logic signed [width_H+width_W-1:0] offset_o,
  output logic                              offset_valid_o
);

  localparam int N  = width_H + width_W;
  localparam int AW = N + avg_log2;
  localparam logic signed [N-1:0] OFFSET_RESET = N'(init_offset);
  localparam logic signed [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};

  typedef enum logic {WARMUP, TRACK} state_t;

  state_t                state, state_next;
  logic signed [AW-1:0]  acc, acc_next, acc_sum, acc_avg;
  logic [avg_log2-1:0]   count, count_next;
  logic signed [N-1:0]   offset_next, data_sat;
  logic signed [N:0]     diff;
  logic                  accumulate, window_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WARMUP;
      acc       <= '0;
      count     <= '0;
      offset_o  <= OFFSET_RESET;
      data_o    <= '0;
      data_o_en <= 1'b0;
    end else begin
      state     <= state_next;
      acc       <= acc_next;
      count     <= count_next;
      offset_o  <= offset_next;
      data_o_en <= data_i_en;
      if (data_i_en)
        data_o <= data_sat;
    end
  end

  always_comb begin
    state_next  = state;
    acc_next    = acc;
    count_next  = count;
    offset_next = offset_o;

    // One extra bit makes overflow visible as a mismatch of the top two bits.
    diff = {data_i[N-1], data_i} - {offset_o[N-1], offset_o};
    if (diff[N] != diff[N-1])
      data_sat = diff[N] ? SAT_MIN : SAT_MAX;
    else
      data_sat = diff[N-1:0];

    acc_sum     = acc + {{avg_log2{data_i[N-1]}}, data_i};
    acc_avg     = acc_sum >>> avg_log2;
    accumulate  = data_i_en && !freeze;
    window_done = accumulate && (count == '1);

    if (accumulate) begin
      count_next = count + avg_log2'(1);
      if (window_done) begin
        acc_next    = '0;
        offset_next = acc_avg[N-1:0];
        state_next  = TRACK;
      end else begin
        acc_next = acc_sum;
      end
    end
  end

  assign offset_valid_o = (state == TRACK);

endmodule

// File: tb/tb_dc_offset_remover.sv
// Directed bench for dc_offset_remover with N=25, window of 4 samples, nominal offset 65536.
module tb_dc_offset_remover;
  localparam int N = 25;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                data_i_en = 1'b0;
  logic signed [N-1:0] data_i = '0;
  logic                freeze = 1'b0;
  logic                data_o_en;
  logic signed [N-1:0] data_o;
  logic signed [N-1:0] offset_o;
  logic                offset_valid_o;

  int errors = 0;
  int checks = 0;

  dc_offset_remover #(
    .width_H(5), .width_W(20), .init_offset(65536), .avg_log2(2)
  ) dut (
    .clk(clk), .rst(rst), .data_i_en(data_i_en), .data_i(data_i), .freeze(freeze),
    .data_o_en(data_o_en), .data_o(data_o), .offset_o(offset_o), .offset_valid_o(offset_valid_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drive at the falling edge, sample 1 time unit after the following rising edge.
  task automatic step(input logic en, input logic signed [N-1:0] d, input logic frz);
    @(negedge clk);
    data_i_en = en;
    data_i    = d;
    freeze    = frz;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input string tag, input logic signed [N-1:0] d, input logic frz,
                      input logic signed [N-1:0] exp);
    step(1'b1, d, frz);
    check({tag, "_en"}, 32'(data_o_en), 1);
    check(tag, 32'(data_o), 32'(exp));
  endtask

  task automatic idle(input string tag, input logic signed [N-1:0] held);
    step(1'b0, '0, 1'b0);
    check({tag, "_en"}, 32'(data_o_en), 0);
    check({tag, "_hold"}, 32'(data_o), 32'(held));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    data_i_en = 1'b1;
    data_i = 25'sd65636;
    freeze = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("rst_no_strobe", 32'(data_o_en), 0);
    end
    check("rst_data", 32'(data_o), 0);
    check("rst_offset", 32'(offset_o), 65536);
    check("rst_valid", 32'(offset_valid_o), 0);
    @(negedge clk);
    rst = 1'b0;
    data_i_en = 1'b0;
  endtask

  task automatic check_offset(input string tag, input logic signed [N-1:0] exp, input logic vld);
    check({tag, "_offset"}, 32'(offset_o), 32'(exp));
    check({tag, "_valid"}, 32'(offset_valid_o), 32'(vld));
  endtask

  initial begin
    // Reset behaviour
    do_reset();

    // Offset tracking, back-to-back
    for (int i = 0; i < 3; i++) send("trk_pre", 25'sd65636, 1'b0, 25'sd100);
    check_offset("trk_3", 25'sd65536, 1'b0);
    send("trk_4", 25'sd65636, 1'b0, 25'sd100);
    check_offset("trk_4", 25'sd65636, 1'b1);
    send("trk_5", 25'sd65636, 1'b0, 25'sd0);
    send("trk_6", 25'sd65636, 1'b0, 25'sd0);
    idle("trk_idle", 25'sd0);

    // Negative saturation, frozen so the window is untouched
    do_reset();
    send("sat_neg", -25'sd16777216, 1'b1, -25'sd16777216);
    check_offset("sat_neg", 25'sd65536, 1'b0);

    // Floor rounding: -1,-1,-1,-2 -> floor(-5/4) = -2
    send("flr_a", -25'sd1, 1'b0, -25'sd65537);
    send("flr_b", -25'sd1, 1'b0, -25'sd65537);
    send("flr_c", -25'sd1, 1'b0, -25'sd65537);
    send("flr_d", -25'sd2, 1'b0, -25'sd65538);
    check_offset("flr_1", -25'sd2, 1'b1);
    // Positive saturation against the negative offset
    send("sat_pos", 25'sd16777215, 1'b1, 25'sd16777215);
    check_offset("sat_pos", -25'sd2, 1'b1);
    // Second window: 0,0,0,3 -> floor(3/4) = 0
    send("flr_e", 25'sd0, 1'b0, 25'sd2);
    send("flr_f", 25'sd0, 1'b0, 25'sd2);
    send("flr_g", 25'sd0, 1'b0, 25'sd2);
    send("flr_h", 25'sd3, 1'b0, 25'sd5);
    check_offset("flr_2", 25'sd0, 1'b1);

    // Gaps of 3 idle cycles between samples
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send("gap", 25'sd65636, 1'b0, 25'sd100);
      if (i < 3) begin
        check_offset("gap_mid", 25'sd65536, 1'b0);
        for (int j = 0; j < 3; j++) idle("gap_idle", 25'sd100);
      end
    end
    check_offset("gap_done", 25'sd65636, 1'b1);

    // Freeze over 2 samples inside a window of 65640s
    send("frz_a", 25'sd65640, 1'b0, 25'sd4);
    send("frz_b", 25'sd65640, 1'b0, 25'sd4);
    send("frz_f1", 25'sd0, 1'b1, -25'sd65636);
    send("frz_f2", 25'sd0, 1'b1, -25'sd65636);
    send("frz_c", 25'sd65640, 1'b0, 25'sd4);
    check_offset("frz_c", 25'sd65636, 1'b1);
    send("frz_d", 25'sd65640, 1'b0, 25'sd4);
    check_offset("frz_done", 25'sd65640, 1'b1);

    // Reset mid-window
    do_reset();
    send("mid_a", 25'sd65636, 1'b0, 25'sd100);
    send("mid_b", 25'sd65636, 1'b0, 25'sd100);
    do_reset();
    for (int i = 0; i < 3; i++) send("mid_post", 25'sd65536, 1'b0, 25'sd0);
    check_offset("mid_3", 25'sd65536, 1'b0);
    send("mid_4", 25'sd65536, 1'b0, 25'sd0);
    check_offset("mid_done", 25'sd65536, 1'b1);
    idle("mid_idle", 25'sd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dc_offset_remover.md
# dc_offset_remover

Receive-side counterpart of the constant-offset adder in the filter chain. A fixed offset is added ahead of the filters; this block removes it downstream. It starts from a known nominal offset, then estimates the real offset as a block average of the incoming samples. Each accepted sample has the current estimate subtracted, with saturation, and the result is re-registered with a one-cycle valid strobe.

## Interface
- width_H, default 5: integer bits of the sample, sign included.
- width_W, default 20: fractional bits of the sample. Sample width is N = width_H+width_W, signed two's complement.
- init_offset, default 65536: offset used from reset until the first estimate exists. Signed integer that fits in N bits.
- avg_log2, default 10: averaging window of 2^avg_log2 accepted samples. Legal range 1..16.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset: rst, synchronous, active-high. Clock: clk.
- data_i_en  in  1  input sample valid, one cycle per sample.
- data_i  in  N  signed input sample, carrying the offset.
- freeze  in  1  when high, offset estimation is suspended.
- data_o_en  out  1  output valid strobe.
- data_o  out  N  signed offset-corrected sample.
- offset_o  out  N  current offset estimate.
- offset_valid_o  out  1  high once at least one window estimate has been loaded.

## Operation
- State machine:
  - WARMUP (reset state): offset_o = init_offset, offset_valid_o = 0.
  - TRACK: entered at the edge that completes the first window. Only rst leaves TRACK.
- Per accepted sample (data_i_en=1):
  - data_o <= sat(data_i - offset_o), using the offset_o value in effect before that edge.
  - data_o_en <= 1.
- Cycles with data_i_en=0:
  - data_o_en <= 0.
  - data_o holds its last value.
  - Accumulator, counter, offset and state all hold.
- Subtraction:
  - Computed at N+1 bits.
  - Saturates to max 2^(N-1)-1 and min -2^(N-1). No wrap.
- Accumulator:
  - Signed, N+avg_log2 bits, so it cannot overflow.
  - Sample counter is avg_log2 bits.
  - Each accepted sample with freeze=0: acc += data_i, counter += 1.
- Window completion: an accepted sample with freeze=0 and counter = 2^avg_log2-1.
  - offset_o <= (acc + data_i) >>> avg_log2. Arithmetic shift, floor toward negative infinity, low N bits.
  - acc <= 0 and counter wraps to 0.
  - offset_valid_o <= 1 (sticky). State becomes TRACK.
  - The completing sample itself is corrected with the old offset.
- freeze=1:
  - Accumulator, counter and offset hold.
  - Correction continues with the held offset.
  - A partial window resumes where it stopped when freeze returns to 0.
- rst mid-window or mid-stream:
  - Partial accumulation is discarded.
  - All state returns to reset values. The next window starts from sample 0.

## Timing
- Reset values: data_o_en=0, data_o=0, offset_o=init_offset, offset_valid_o=0, acc=0, counter=0, state WARMUP.
- rst has priority over data_i_en and freeze.
- Latency is 1 cycle: a sample accepted at edge k gives data_o/data_o_en visible after edge k.
- Back-to-back samples are accepted every cycle; there is no backpressure.
- New offset_o and offset_valid_o are visible after the completing edge. The next accepted sample uses the new offset.
- data_o_en is a single-cycle strobe per sample. It is never held high without a new sample.

## Test plan
All scenarios use width_H=5, width_W=20 (N=25), avg_log2=2 (window 4), init_offset=65536.
- Reset behaviour: assert rst 2 cycles, with data_i_en=1 during rst.
  - Required: data_o_en=0, data_o=0, offset_o=65536, offset_valid_o=0. No strobe during rst.
- Offset tracking: 6 back-to-back samples of 65636.
  - Required: first 4 outputs 100.
  - offset_o becomes 65636 and offset_valid_o rises after the 4th edge.
  - Outputs 5 and 6 are 0.
  - Each output appears exactly 1 cycle after its input.
- Floor rounding: after a window completes, offset_o follows the floored average of its 4 samples.
  - First window: samples -1, -1, -1, -2 (sum -5) → offset_o = -2.
  - Second window: next sample 0 gives data_o=2; samples 0, 0, 0, 3 (sum 3) → offset_o = 0.
- Saturation: input -16777216 with offset 65536 → data_o = -16777216.
  - Then with offset forced negative via the floor-rounding window, input 16777215 → data_o = 16777215.
- Gaps and freeze:
  - Samples with 3 idle cycles between them: no strobes in the gaps, and the window completes only on the 4th accepted sample.
  - freeze=1 over 2 samples: those samples are corrected but not counted, and the window completes 2 samples later.
- Reset mid-window: reset after 2 of 4 samples of 65636.
  - Required: offset_o=65536 and offset_valid_o=0 after reset.
  - The next 4 samples of 65536 give offset_o=65536. No stale contribution carries over.
